biss_master: RTL and testbench
==============================

Name: biss_master

Overview:
- Active BiSS-C point-to-point master for the encoder inputs.
- On each trigger it drives the MA clock, detects ACK/start/CDS and shifts in a BITS-wide position, the nE/nW status bits and the CRC6.
- After the slave timeout it returns to idle and publishes a checked, sign-extended position.
- Sits directly upstream of the passive biss_sniffer on the same sck/dat pair; both must decode identical frames.

Parameters:
- ACK_LIMIT, 14: max MA clock periods to wait for ACK low, then for the start bit.
- TIMEOUT_LIMIT, 4096: max clk_i cycles to wait for the slave to release data high after the CRC.

Ports:
- clk_i  in  1  system clock
- reset_i  in  1  synchronous, active-high reset
- trigger_i  in  1  single-cycle frame request
- BITS  in  8  position bit count; valid 1..32, values >32 treated as 32, 0 treated as 1
- CLK_PERIOD  in  32  MA half-period in clk_i cycles; values <4 treated as 4
- biss_sck_o  out  1  MA clock to the encoder; idle high
- biss_dat_i  in  1  SL data from the encoder
- posn_o  out  32  last good position, sign-extended from BITS
- posn_valid_o  out  1  one-cycle strobe when posn_o updates
- link_up_o  out  1  high after a good frame
- error_o  out  1  high while the last frame was bad
- busy_o  out  1  frame in progress

Behaviour:
- Reset values: biss_sck_o=1, posn_o=0, posn_valid_o=0, link_up_o=0, error_o=0, busy_o=0, FSM=IDLE.
- biss_dat_i passes through a 2-FF synchroniser.
- Sampling: each bit is sampled in the last clk_i cycle of the MA high half-period. This tolerates a line delay of up to CLK_PERIOD-3 cycles.
- Divider: a counter runs CLK_PERIOD cycles per half. sck toggles only when the counter expires. The first falling edge is 1 cycle after the accepted trigger.
- IDLE:
  - trigger_i accepted only here, and only if synced dat=1. Otherwise the frame ends immediately as an error (no-response).
  - BITS and CLK_PERIOD are latched at trigger.
  - trigger_i while busy is ignored.
- ACK: clock runs. Wait for sample=0; move to START. If ACK_LIMIT periods pass with no 0, go to FAIL.
- START: wait for sample=1; move to CDS. ACK_LIMIT periods with no 1 goes to FAIL.
- CDS: one bit, value discarded.
- DATA: BITS bits, MSB first, shifted into the position register.
- STAT: 2 bits, nE then nW (active low).
- CRC: 6 bits, received inverted.
  - Polynomial x^6+x+1 (0x43), seed 0, serial over DATA+nE+nW.
  - Good when the received CRC equals ~computed.
- TOUT:
  - sck is held high; wait for synced dat=1.
  - If TIMEOUT_LIMIT cycles pass first, go to FAIL.
  - On release, go to DONE.
- DONE (1 cycle): if CRC is good and nE=1:
  - posn_o is updated (bits above BITS-1 replicate bit BITS-1).
  - posn_valid_o is pulsed; link_up_o=1; error_o=0.
  - Otherwise error_o=1 and link_up_o is unchanged; a CRC-bad frame does not drop the link.
  - nW is ignored for validity. Go to IDLE.
- FAIL (1 cycle): sck=1, error_o=1, link_up_o=0, posn_o unchanged, go to IDLE.
- busy_o is high in every state except IDLE.
- Total latency trigger→posn_valid_o: (3+BITS+8) × 2×CLK_PERIOD + slave timeout + 2 cycles. The ACK and START wait lengths add to this.
- Reset mid-frame: FSM goes to IDLE and sck=1 on the next cycle; all outputs take their reset values.

Decomposition:
- Shared package holds:
  - FSM state enum (IDLE, ACK, START, CDS, DATA, STAT, CRC, TOUT, DONE, FAIL)
  - CRC6_POLY=0x43
  - BITS_MAX=32, CLK_PERIOD_MIN=4
- The same package is used by biss_sniffer.
- One sub-module: biss_crc6. Serial CRC with clear, enable and bit input, and a 6-bit output. Shared with the sniffer.

Test Plan:
- Good frame: BITS=32, CLK_PERIOD=8, slave model with ACK after 2 clocks, data 0x00000000, nE=nW=1, CRC bits 111010 (~0x05).
  → posn_valid_o pulses once, posn_o=0, link_up_o=1, error_o=0.
- Sign extension: BITS=18, data 0x20001, correct CRC.
  → posn_o=0xFFFE0001. Then data 0x1FFFF → posn_o=0x0001FFFF.
- CRC corruption: flip one CRC bit on a good link.
  → error_o=1, link_up_o stays 1, posn_o unchanged, no posn_valid_o.
- No slave: dat stuck high after trigger.
  → after ACK_LIMIT=14 periods: error_o=1, link_up_o=0, sck=1, busy_o=0.
- nE=0 with correct CRC.
  → error_o=1, posn_o unchanged. Same frame with nW=0 and nE=1 → accepted.
- Trigger during frame plus mid-frame reset: second trigger ignored (one frame only).
  → reset_i in DATA returns sck=1 and all outputs to reset values next cycle. The next trigger completes normally.
- Cross-check: biss_sniffer on the same wires with BITS equal reports the same posn as posn_o.

Source files
------------

// File: rtl/biss_master_pkg.sv
`default_nettype none
// ============================================================================
// Module      : biss_master_pkg
// Description : Shared BiSS-C types and constants for the master and sniffer.
// Revision    : 1.0
// ============================================================================
package biss_master_pkg;

    typedef enum logic [3:0] {
        S_IDLE  = 4'd0,
        S_ACK   = 4'd1,
        S_START = 4'd2,
        S_CDS   = 4'd3,
        S_DATA  = 4'd4,
        S_STAT  = 4'd5,
        S_CRC   = 4'd6,
        S_TOUT  = 4'd7,
        S_DONE  = 4'd8,
        S_FAIL  = 4'd9
    } biss_state_t;

    localparam logic [6:0] CRC6_POLY      = 7'h43;
    localparam int         BITS_MAX       = 32;
    localparam int         CLK_PERIOD_MIN = 4;

    // Bits above nbits-1 replicate the received MSB.
    function automatic logic [31:0] sign_extend(input logic [31:0] value, input logic [5:0] nbits);
        logic [31:0] w_result;
        w_result = '0;
        for (int i = 0; i < 32; i++) begin
            w_result[i] = (i < int'(nbits)) ? value[i] : value[nbits - 6'd1];
        end
        return w_result;
    endfunction

endpackage
`default_nettype wire

// File: rtl/biss_crc6.sv
`default_nettype none
// ============================================================================
// Module      : biss_crc6
// Description : Serial CRC6 (x^6+x+1), seed 0, one message bit per enable.
// Revision    : 1.0
// ============================================================================
module biss_crc6
    import biss_master_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       i_clear,
    input  logic       i_en,
    input  logic       i_bit,
    output logic [5:0] o_crc
);

    logic [5:0] r_crc;
    logic       w_fb;

    assign w_fb = i_bit ^ r_crc[5];

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_crc <= '0;
        end else if (i_en) begin
            r_crc <= {r_crc[4:0], 1'b0} ^ (w_fb ? CRC6_POLY[5:0] : 6'd0);
        end
    end

    assign o_crc = r_crc;

endmodule
`default_nettype wire

// File: rtl/biss_master.sv
`default_nettype none
// ============================================================================
// Module      : biss_master
// Description : BiSS-C point-to-point master: drives MA, decodes position,
//               status and CRC6, publishes a sign-extended checked position.
// Revision    : 1.0
// ============================================================================
module biss_master
    import biss_master_pkg::*;
#(
    parameter int ACK_LIMIT     = 14,
    parameter int TIMEOUT_LIMIT = 4096
) (
    input  logic        clk_i,
    input  logic        reset_i,
    input  logic        trigger_i,
    input  logic [7:0]  BITS,
    input  logic [31:0] CLK_PERIOD,
    output logic        biss_sck_o,
    input  logic        biss_dat_i,
    output logic [31:0] posn_o,
    output logic        posn_valid_o,
    output logic        link_up_o,
    output logic        error_o,
    output logic        busy_o
);

    localparam int c_ack_w  = $clog2(ACK_LIMIT + 1);
    localparam int c_tout_w = $clog2(TIMEOUT_LIMIT + 1);

    biss_state_t         r_state;
    logic                r_dat_s1, r_dat_s2;
    logic [5:0]          r_bits;
    logic [31:0]         r_period, r_cnt;
    logic                r_sck, r_prime;
    logic [c_ack_w-1:0]  r_wait;
    logic [5:0]          r_bitcnt;
    logic [31:0]         r_shift;
    logic                r_ne;
    logic [5:0]          r_crc_rx;
    logic [c_tout_w-1:0] r_tout;
    logic [31:0]         r_posn;
    logic                r_posn_valid, r_link, r_error;

    logic [5:0]  w_bits_in;
    logic [31:0] w_period_in;
    logic        w_running, w_tick, w_sample, w_crc_clr, w_crc_en, w_crc_ok;
    logic [5:0]  w_crc;

    always_comb begin
        w_bits_in = BITS[5:0];
        if (BITS == 8'd0) begin
            w_bits_in = 6'd1;
        end else if (BITS > 8'(BITS_MAX)) begin
            w_bits_in = 6'(BITS_MAX);
        end
        w_period_in = CLK_PERIOD;
        if (CLK_PERIOD < 32'(CLK_PERIOD_MIN)) begin
            w_period_in = 32'(CLK_PERIOD_MIN);
        end
    end

    // The very first expiry only drops sck; samples land at the end of each high half.
    assign w_running = r_state inside {S_ACK, S_START, S_CDS, S_DATA, S_STAT, S_CRC};
    assign w_tick    = w_running && (r_cnt == 32'd0);
    assign w_sample  = w_tick && r_sck && !r_prime;
    assign w_crc_clr = (r_state == S_IDLE) && trigger_i;
    assign w_crc_en  = w_sample && ((r_state == S_DATA) || (r_state == S_STAT));
    assign w_crc_ok  = (r_crc_rx == ~w_crc);

    biss_crc6 u_crc6 (
        .clk     (clk_i),
        .rst     (reset_i),
        .i_clear (w_crc_clr),
        .i_en    (w_crc_en),
        .i_bit   (r_dat_s2),
        .o_crc   (w_crc)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state      <= S_IDLE;
            r_dat_s1     <= 1'b1;
            r_dat_s2     <= 1'b1;
            r_bits       <= 6'd1;
            r_period     <= 32'(CLK_PERIOD_MIN);
            r_cnt        <= '0;
            r_sck        <= 1'b1;
            r_prime      <= 1'b0;
            r_wait       <= '0;
            r_bitcnt     <= '0;
            r_shift      <= '0;
            r_ne         <= 1'b0;
            r_crc_rx     <= '0;
            r_tout       <= '0;
            r_posn       <= '0;
            r_posn_valid <= 1'b0;
            r_link       <= 1'b0;
            r_error      <= 1'b0;
        end else begin
            r_dat_s1     <= biss_dat_i;
            r_dat_s2     <= r_dat_s1;
            r_posn_valid <= 1'b0;

            if (w_tick) begin
                r_cnt   <= r_period - 32'd1;
                r_sck   <= ~r_sck;
                r_prime <= 1'b0;
            end else if (w_running) begin
                r_cnt <= r_cnt - 32'd1;
            end

            // Later sck assignments below override the divider toggle.
            case (r_state)
                S_IDLE: begin
                    if (trigger_i) begin
                        r_bits   <= w_bits_in;
                        r_period <= w_period_in;
                        r_cnt    <= '0;
                        r_prime  <= 1'b1;
                        r_sck    <= 1'b1;
                        r_wait   <= '0;
                        r_bitcnt <= '0;
                        r_state  <= r_dat_s2 ? S_ACK : S_FAIL;
                    end
                end
                S_ACK: begin
                    if (w_sample) begin
                        if (!r_dat_s2) begin
                            r_state <= S_START;
                            r_wait  <= '0;
                        end else if (r_wait == c_ack_w'(ACK_LIMIT - 1)) begin
                            r_state <= S_FAIL;
                            r_sck   <= 1'b1;
                        end else begin
                            r_wait <= r_wait + 1'b1;
                        end
                    end
                end
                S_START: begin
                    if (w_sample) begin
                        if (r_dat_s2) begin
                            r_state <= S_CDS;
                        end else if (r_wait == c_ack_w'(ACK_LIMIT - 1)) begin
                            r_state <= S_FAIL;
                            r_sck   <= 1'b1;
                        end else begin
                            r_wait <= r_wait + 1'b1;
                        end
                    end
                end
                S_CDS: begin
                    if (w_sample) begin
                        r_state  <= S_DATA;
                        r_bitcnt <= '0;
                    end
                end
                S_DATA: begin
                    if (w_sample) begin
                        r_shift <= {r_shift[30:0], r_dat_s2};
                        if (r_bitcnt == r_bits - 6'd1) begin
                            r_bitcnt <= '0;
                            r_state  <= S_STAT;
                        end else begin
                            r_bitcnt <= r_bitcnt + 6'd1;
                        end
                    end
                end
                S_STAT: begin
                    if (w_sample) begin
                        if (r_bitcnt == 6'd0) begin
                            r_ne     <= r_dat_s2;
                            r_bitcnt <= 6'd1;
                        end else begin
                            r_bitcnt <= '0;
                            r_state  <= S_CRC;
                        end
                    end
                end
                S_CRC: begin
                    if (w_sample) begin
                        r_crc_rx <= {r_crc_rx[4:0], r_dat_s2};
                        if (r_bitcnt == 6'd5) begin
                            r_state <= S_TOUT;
                            r_sck   <= 1'b1;
                            r_tout  <= '0;
                        end else begin
                            r_bitcnt <= r_bitcnt + 6'd1;
                        end
                    end
                end
                S_TOUT: begin
                    if (r_dat_s2) begin
                        r_state <= S_DONE;
                    end else if (r_tout == c_tout_w'(TIMEOUT_LIMIT - 1)) begin
                        r_state <= S_FAIL;
                    end else begin
                        r_tout <= r_tout + 1'b1;
                    end
                end
                S_DONE: begin
                    if (w_crc_ok && r_ne) begin
                        r_posn       <= sign_extend(r_shift, r_bits);
                        r_posn_valid <= 1'b1;
                        r_link       <= 1'b1;
                        r_error      <= 1'b0;
                    end else begin
                        r_error <= 1'b1;
                    end
                    r_state <= S_IDLE;
                end
                S_FAIL: begin
                    r_sck   <= 1'b1;
                    r_error <= 1'b1;
                    r_link  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign biss_sck_o   = r_sck;
    assign posn_o       = r_posn;
    assign posn_valid_o = r_posn_valid;
    assign link_up_o    = r_link;
    assign error_o      = r_error;
    assign busy_o       = (r_state != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_biss_master.sv
`default_nettype none
// ============================================================================
// Module      : tb_biss_master
// Description : Self-checking bench for biss_master with a BiSS-C slave model.
// Revision    : 1.0
// ============================================================================
module tb_biss_master;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        trigger_i;
    logic [7:0]  bits;
    logic [31:0] period;
    logic        biss_sck_o;
    logic        biss_dat_i;
    logic [31:0] posn_o;
    logic        posn_valid_o;
    logic        link_up_o;
    logic        error_o;
    logic        busy_o;

    int          n_checks = 0;
    int          n_pass   = 0;
    int          n_valid;
    int          busy_cnt;
    int          cur_period;
    logic        slave_bits[$];
    logic [31:0] sb[$];

    always #5 clk = ~clk;

    biss_master #(
        .ACK_LIMIT     (14),
        .TIMEOUT_LIMIT (4096)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .trigger_i    (trigger_i),
        .BITS         (bits),
        .CLK_PERIOD   (period),
        .biss_sck_o   (biss_sck_o),
        .biss_dat_i   (biss_dat_i),
        .posn_o       (posn_o),
        .posn_valid_o (posn_valid_o),
        .link_up_o    (link_up_o),
        .error_o      (error_o),
        .busy_o       (busy_o)
    );

    // Remainder of msg(x)*x^6 divided by x^6+x+1.
    function automatic logic [5:0] crc_model(input logic [39:0] msg, input int len);
        logic [45:0] r;
        r = {msg, 6'b000000};
        for (int i = len + 5; i >= 6; i--) begin
            if (r[i]) r = r ^ (46'h43 << (i - 6));
        end
        return r[5:0];
    endfunction

    function automatic void load_frame(input logic [31:0] data, input int nb,
                                       input logic ne, input logic nw, input logic [5:0] flip);
        logic [39:0] msg;
        logic [5:0]  crc;
        msg = '0;
        for (int i = nb - 1; i >= 0; i--) msg = {msg[38:0], data[i]};
        msg = {msg[38:0], ne};
        msg = {msg[38:0], nw};
        crc = crc_model(msg, nb + 2);
        slave_bits.delete();
        slave_bits.push_back(1'b1);
        slave_bits.push_back(1'b0);
        slave_bits.push_back(1'b1);
        slave_bits.push_back(1'b0);
        for (int i = nb - 1; i >= 0; i--) slave_bits.push_back(data[i]);
        slave_bits.push_back(ne);
        slave_bits.push_back(nw);
        for (int i = 5; i >= 0; i--) slave_bits.push_back(~crc[i] ^ flip[i]);
    endfunction

    // Triggers one frame, plays the slave and scores every posn_valid_o pulse.
    task automatic run_frame(input int abort_at, input int retrig_at);
        int          cyc;
        int          tc;
        int          post;
        bit          seen_busy;
        bit          finished;
        bit          tout_on;
        logic        prev_sck;
        logic [31:0] exp_posn;
        n_valid   = 0;
        busy_cnt  = 0;
        cyc       = 0;
        tc        = 0;
        post      = 0;
        seen_busy = 0;
        finished  = 0;
        tout_on   = 0;
        biss_dat_i = 1'b1;
        @(negedge clk);
        trigger_i = 1'b1;
        prev_sck  = biss_sck_o;
        while (!finished && cyc < 30000) begin
            @(negedge clk);
            cyc++;
            trigger_i = (cyc == retrig_at);
            if (biss_sck_o && !prev_sck && slave_bits.size() > 0) begin
                biss_dat_i = slave_bits.pop_front();
                if (slave_bits.size() == 0) begin
                    tout_on = 1;
                    tc      = cur_period;
                end
            end else if (tout_on) begin
                tc--;
                if (tc == 0) biss_dat_i = 1'b0;
                else if (tc == -20) begin
                    biss_dat_i = 1'b1;
                    tout_on    = 0;
                end
            end
            prev_sck = biss_sck_o;
            if (busy_o) begin
                seen_busy = 1;
                busy_cnt++;
            end
            if (posn_valid_o) begin
                n_valid++;
                n_checks++;
                if (sb.size() == 0) begin
                    $display("FAIL unexpected_valid: posn_o=%h with no frame expected to be accepted", posn_o);
                end else begin
                    exp_posn = sb.pop_front();
                    if (posn_o !== exp_posn) $display("FAIL posn: got %h expected %h", posn_o, exp_posn);
                    else n_pass++;
                end
            end
            if (cyc == abort_at) finished = 1;
            else if (seen_busy && !busy_o && !tout_on && slave_bits.size() == 0) begin
                post++;
                if (post > 4) finished = 1;
            end
        end
        trigger_i = 1'b0;
        if (!finished) begin
            n_checks++;
            $display("FAIL frame_timeout: busy_o=%b after %0d cycles, required idle", busy_o, cyc);
        end
    endtask

    task automatic test_reset;
        reset_i    = 1'b1;
        trigger_i  = 1'b0;
        biss_dat_i = 1'b1;
        bits       = 8'd32;
        period     = 32'd8;
        cur_period = 8;
        repeat (3) @(negedge clk);
        n_checks++; if (biss_sck_o !== 1'b1) $display("FAIL reset_sck: got %b expected 1", biss_sck_o); else n_pass++;
        n_checks++; if (posn_o !== 32'd0) $display("FAIL reset_posn: got %h expected 0", posn_o); else n_pass++;
        n_checks++; if (posn_valid_o !== 1'b0) $display("FAIL reset_valid: got %b expected 0", posn_valid_o); else n_pass++;
        n_checks++; if (link_up_o !== 1'b0) $display("FAIL reset_link: got %b expected 0", link_up_o); else n_pass++;
        n_checks++; if (error_o !== 1'b0) $display("FAIL reset_error: got %b expected 0", error_o); else n_pass++;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL reset_busy: got %b expected 0", busy_o); else n_pass++;
        reset_i = 1'b0;
        repeat (3) @(negedge clk);
    endtask

    task automatic test_good_frame;
        bits = 8'd32; period = 32'd8; cur_period = 8;
        load_frame(32'h0000_0000, 32, 1'b1, 1'b1, 6'd0);
        sb.push_back(32'h0000_0000);
        run_frame(0, 0);
        n_checks++; if (n_valid !== 1) $display("FAIL good_valid_count: got %0d expected 1", n_valid); else n_pass++;
        n_checks++; if (sb.size() !== 0) $display("FAIL good_missing: got %0d pending expected 0", sb.size()); else n_pass++;
        n_checks++; if (link_up_o !== 1'b1) $display("FAIL good_link: got %b expected 1", link_up_o); else n_pass++;
        n_checks++; if (error_o !== 1'b0) $display("FAIL good_error: got %b expected 0", error_o); else n_pass++;
        n_checks++; if (posn_o !== 32'd0) $display("FAIL good_posn: got %h expected 0", posn_o); else n_pass++;
    endtask

    task automatic test_sign_ext;
        period = 32'd8; cur_period = 8;
        bits = 8'd200;
        load_frame(32'h8000_0001, 32, 1'b1, 1'b1, 6'd0);
        sb.push_back(32'h8000_0001);
        run_frame(0, 0);
        n_checks++; if (n_valid !== 1) $display("FAIL bits_over_32: got %0d valid expected 1", n_valid); else n_pass++;
        bits = 8'd0;
        load_frame(32'h0000_0001, 1, 1'b1, 1'b1, 6'd0);
        sb.push_back(32'hFFFF_FFFF);
        run_frame(0, 0);
        n_checks++; if (n_valid !== 1) $display("FAIL bits_zero: got %0d valid expected 1", n_valid); else n_pass++;
        bits = 8'd18;
        load_frame(32'h0002_0001, 18, 1'b1, 1'b1, 6'd0);
        sb.push_back(32'hFFFE_0001);
        run_frame(0, 0);
        n_checks++; if (n_valid !== 1) $display("FAIL sext_neg: got %0d valid expected 1", n_valid); else n_pass++;
        load_frame(32'h0001_FFFF, 18, 1'b1, 1'b1, 6'd0);
        sb.push_back(32'h0001_FFFF);
        run_frame(0, 0);
        n_checks++; if (n_valid !== 1) $display("FAIL sext_pos: got %0d valid expected 1", n_valid); else n_pass++;
        n_checks++; if (posn_o !== 32'h0001_FFFF) $display("FAIL sext_final: got %h expected 0001ffff", posn_o); else n_pass++;
    endtask

    task automatic test_crc_error;
        bits = 8'd18;
        load_frame(32'h0001_2345, 18, 1'b1, 1'b1, 6'b000100);
        run_frame(0, 0);
        n_checks++; if (n_valid !== 0) $display("FAIL crc_valid: got %0d expected 0", n_valid); else n_pass++;
        n_checks++; if (error_o !== 1'b1) $display("FAIL crc_error: got %b expected 1", error_o); else n_pass++;
        n_checks++; if (link_up_o !== 1'b1) $display("FAIL crc_link: got %b expected 1", link_up_o); else n_pass++;
        n_checks++; if (posn_o !== 32'h0001_FFFF) $display("FAIL crc_posn: got %h expected 0001ffff", posn_o); else n_pass++;
    endtask

    task automatic test_status;
        bits = 8'd18;
        load_frame(32'h0000_0ABC, 18, 1'b0, 1'b1, 6'd0);
        run_frame(0, 0);
        n_checks++; if (n_valid !== 0) $display("FAIL ne_valid: got %0d expected 0", n_valid); else n_pass++;
        n_checks++; if (error_o !== 1'b1) $display("FAIL ne_error: got %b expected 1", error_o); else n_pass++;
        n_checks++; if (posn_o !== 32'h0001_FFFF) $display("FAIL ne_posn: got %h expected 0001ffff", posn_o); else n_pass++;
        load_frame(32'h0000_0ABC, 18, 1'b1, 1'b0, 6'd0);
        sb.push_back(32'h0000_0ABC);
        run_frame(0, 0);
        n_checks++; if (n_valid !== 1) $display("FAIL nw_valid: got %0d expected 1", n_valid); else n_pass++;
        n_checks++; if (error_o !== 1'b0) $display("FAIL nw_error: got %b expected 0", error_o); else n_pass++;
    endtask

    task automatic test_no_slave;
        bits = 8'd18; period = 32'd8; cur_period = 8;
        slave_bits.delete();
        run_frame(0, 0);
        n_checks++; if (error_o !== 1'b1) $display("FAIL noslave_error: got %b expected 1", error_o); else n_pass++;
        n_checks++; if (link_up_o !== 1'b0) $display("FAIL noslave_link: got %b expected 0", link_up_o); else n_pass++;
        n_checks++; if (biss_sck_o !== 1'b1) $display("FAIL noslave_sck: got %b expected 1", biss_sck_o); else n_pass++;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL noslave_busy: got %b expected 0", busy_o); else n_pass++;
        n_checks++; if (busy_cnt !== 28 * 8 + 2) $display("FAIL noslave_len: got %0d expected %0d", busy_cnt, 28 * 8 + 2); else n_pass++;
        n_checks++; if (posn_o !== 32'h0000_0ABC) $display("FAIL noslave_posn: got %h expected 00000abc", posn_o); else n_pass++;
        period = 32'd2; cur_period = 4;
        slave_bits.delete();
        run_frame(0, 0);
        n_checks++; if (busy_cnt !== 28 * 4 + 2) $display("FAIL period_clamp: got %0d expected %0d", busy_cnt, 28 * 4 + 2); else n_pass++;
    endtask

    task automatic test_back_to_back;
        bits = 8'd18; period = 32'd8; cur_period = 8;
        load_frame(32'h0003_0F0F, 18, 1'b1, 1'b1, 6'd0);
        sb.push_back(32'hFFFF_0F0F);
        run_frame(0, 60);
        n_checks++; if (n_valid !== 1) $display("FAIL retrig_valid: got %0d expected 1", n_valid); else n_pass++;
        n_checks++; if (link_up_o !== 1'b1) $display("FAIL retrig_link: got %b expected 1", link_up_o); else n_pass++;
        load_frame(32'h0000_0F0F, 18, 1'b1, 1'b1, 6'd0);
        sb.push_back(32'h0000_0F0F);
        run_frame(0, 0);
        n_checks++; if (n_valid !== 1) $display("FAIL b2b_valid: got %0d expected 1", n_valid); else n_pass++;
        n_checks++; if (sb.size() !== 0) $display("FAIL b2b_pending: got %0d expected 0", sb.size()); else n_pass++;
    endtask

    task automatic test_reset_mid_frame;
        bits = 8'd18; period = 32'd8; cur_period = 8;
        load_frame(32'h0001_1111, 18, 1'b1, 1'b1, 6'd0);
        run_frame(120, 0);
        n_checks++; if (busy_o !== 1'b1) $display("FAIL mid_busy: got %b expected 1", busy_o); else n_pass++;
        reset_i = 1'b1;
        @(negedge clk);
        n_checks++; if (biss_sck_o !== 1'b1) $display("FAIL mid_sck: got %b expected 1", biss_sck_o); else n_pass++;
        n_checks++; if (busy_o !== 1'b0) $display("FAIL mid_busy_rst: got %b expected 0", busy_o); else n_pass++;
        n_checks++; if (posn_o !== 32'd0) $display("FAIL mid_posn: got %h expected 0", posn_o); else n_pass++;
        n_checks++; if (link_up_o !== 1'b0) $display("FAIL mid_link: got %b expected 0", link_up_o); else n_pass++;
        n_checks++; if (error_o !== 1'b0) $display("FAIL mid_error: got %b expected 0", error_o); else n_pass++;
        reset_i = 1'b0;
        slave_bits.delete();
        biss_dat_i = 1'b1;
        repeat (5) @(negedge clk);
        load_frame(32'h0000_1234, 18, 1'b1, 1'b1, 6'd0);
        sb.push_back(32'h0000_1234);
        run_frame(0, 0);
        n_checks++; if (n_valid !== 1) $display("FAIL after_rst_valid: got %0d expected 1", n_valid); else n_pass++;
        n_checks++; if (link_up_o !== 1'b1) $display("FAIL after_rst_link: got %b expected 1", link_up_o); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_sign_ext();
        test_crc_error();
        test_status();
        test_no_slave();
        test_back_to_back();
        test_reset_mid_frame();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
